qspi_target: RTL and testbench

- SPI/Dual/Quad target (slave) for the team's QSPI master; sits on the flash/peripheral side of the `cs_n`/`sclk`/IO[3:0] bus.
- Oversamples the bus in the `sys_clk` domain.
- Direction is set by the `operation` sideband shared with the master:
  - Write: the target captures a DATA_WIDTH word.
  - Read: the target drives a DATA_WIDTH word.
- Local logic exchanges words through `rx_data`/`rx_valid` and `tx_data`/`tx_load`.

---
 rtl/qspi_pkg.sv | 27 ++
 rtl/qspi_sync_edge.sv | 33 +++
 rtl/qspi_target.sv | 204 ++++++++++++++++++++
 tb/tb_qspi_target.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI target: bus mode encoding, target FSM states
// and the lanes-per-edge lookup.
package qspi_pkg;

   typedef enum logic [1:0] {
      MODE_SPI  = 2'b00,
      MODE_DUAL = 2'b01,
      MODE_QUAD = 2'b10
   } qspi_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] MODE_RSVD = 2'b11;

   function automatic logic [2:0] lanes_per_edge(input qspi_mode_t mode);
      case (mode)
         MODE_DUAL: lanes_per_edge = 3'd2;
         MODE_QUAD: lanes_per_edge = 3'd4;
         default:   lanes_per_edge = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse detection on the synchronized level.
// STAGES must be at least 2.
module qspi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic nrst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // synchronizer chain plus a delayed copy of its output for edge detection
   always_ff @(posedge sys_clk or negedge nrst) begin
      if (!nrst) begin
         sync_r <= {STAGES{RESET_VAL}};
         prev_r <= RESET_VAL;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign q    = sync_r[STAGES-1];
   assign rise = sync_r[STAGES-1] & ~prev_r;
   assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/qspi_target.sv
// SPI/Dual/Quad target oversampling cs_n/sclk/IO in the sys_clk domain.
// Optional macro QSPI_TARGET_AUTO_ECHO_EN: each received word is reloaded into tx_buffer.
module qspi_target
   import qspi_pkg::*;
#(
   parameter int   DATA_WIDTH  = 8,
   parameter logic CPOL        = 1'b1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  nrst,
   input  logic [1:0]            sel_mode,
   input  logic                  operation,
   input  logic                  cs_n,
   input  logic                  sclk,
   inout  wire  [3:0]            IO,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_busy,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                          state_r, state_nxt_s;
   logic [1:0]                      mode_r;
   logic                            op_r;
   logic [DATA_WIDTH-1:0]           shift_r, tx_buffer_r, cap_s, adv_s;
   logic [CNT_W-1:0]                bit_cnt_r, lanes_s;
   logic                            overrun_r, adv_pend_r, mode_ok_s, drive_en_s;
   logic                            cs_q_s, cs_rise_s, cs_fall_s;
   logic                            sclk_s, sclk_rise_s, sclk_fall_s;
   logic [SYNC_STAGES-1:0][3:0]     io_sync_r;
   logic [3:0]                      io_s, lane_oe_s, io_oe_s, io_do_s;

   qspi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .sys_clk (sys_clk), .nrst (nrst), .d (cs_n),
      .q (cs_q_s), .rise (cs_rise_s), .fall (cs_fall_s)
   );

   qspi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
      .sys_clk (sys_clk), .nrst (nrst), .d (sclk),
      .q (sclk_s), .rise (sclk_rise_s), .fall (sclk_fall_s)
   );

   // IO lanes share the sclk synchronizer depth so sampled data lines up with the edge
   always_ff @(posedge sys_clk or negedge nrst) begin
      if (!nrst) begin
         io_sync_r <= {SYNC_STAGES{4'b0000}};
      end else begin
         io_sync_r <= {io_sync_r[SYNC_STAGES-2:0], IO};
      end
   end

   assign io_s      = io_sync_r[SYNC_STAGES-1];
   assign mode_ok_s = (mode_r != MODE_RSVD);
   assign lanes_s   = CNT_W'(lanes_per_edge(qspi_mode_t'(mode_r)));

   // lane mapping: MSB of each group sits on the lowest lane index
   always_comb begin
      cap_s     = shift_r;
      adv_s     = shift_r;
      lane_oe_s = 4'b0000;
      io_do_s   = 4'b0000;
      case (mode_r)
         MODE_SPI: begin
            cap_s     = {shift_r[DATA_WIDTH-2:0], io_s[0]};
            adv_s     = {shift_r[DATA_WIDTH-2:0], 1'b0};
            lane_oe_s = 4'b0010;
            io_do_s   = {2'b00, shift_r[DATA_WIDTH-1], 1'b0};
         end
         MODE_DUAL: begin
            cap_s     = {shift_r[DATA_WIDTH-3:0], io_s[0], io_s[1]};
            adv_s     = {shift_r[DATA_WIDTH-3:0], 2'b00};
            lane_oe_s = 4'b0011;
            io_do_s   = {2'b00, shift_r[DATA_WIDTH-2], shift_r[DATA_WIDTH-1]};
         end
         MODE_QUAD: begin
            cap_s     = {shift_r[DATA_WIDTH-5:0], io_s[0], io_s[1], io_s[2], io_s[3]};
            adv_s     = {shift_r[DATA_WIDTH-5:0], 4'b0000};
            lane_oe_s = 4'b1111;
            io_do_s   = {shift_r[DATA_WIDTH-4], shift_r[DATA_WIDTH-3],
                         shift_r[DATA_WIDTH-2], shift_r[DATA_WIDTH-1]};
         end
         default: begin
            cap_s     = shift_r;
            adv_s     = shift_r;
            lane_oe_s = 4'b0000;
            io_do_s   = 4'b0000;
         end
      endcase
   end

   // cs_q_s goes high in the very cycle the synchronized rise is seen, releasing IO at once
   assign drive_en_s = (state_r == SHIFT) && !op_r && !cs_q_s;
   assign io_oe_s    = drive_en_s ? lane_oe_s : 4'b0000;

   for (genvar i = 0; i < 4; i++) begin : g_io
      assign IO[i] = io_oe_s[i] ? io_do_s[i] : 1'bz;
   end

   // FSM state register
   always_ff @(posedge sys_clk or negedge nrst) begin
      if (!nrst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (cs_fall_s) state_nxt_s = SHIFT;
            else           state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (cs_rise_s) state_nxt_s = DONE;
            else           state_nxt_s = SHIFT;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // frame datapath: snapshot, shift/drive, completion status
   always_ff @(posedge sys_clk or negedge nrst) begin
      if (!nrst) begin
         mode_r     <= 2'b00;
         op_r       <= 1'b0;
         shift_r    <= {DATA_WIDTH{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         overrun_r  <= 1'b0;
         adv_pend_r <= 1'b0;
         tx_busy    <= 1'b0;
         rx_data    <= {DATA_WIDTH{1'b0}};
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cs_fall_s) begin
                  mode_r     <= sel_mode;
                  op_r       <= operation;
                  shift_r    <= tx_buffer_r;
                  bit_cnt_r  <= CNT_W'(DATA_WIDTH);
                  overrun_r  <= 1'b0;
                  adv_pend_r <= 1'b0;
                  tx_busy    <= 1'b1;
                  frame_err  <= (sclk_s != CPOL);
               end
            end
            SHIFT: begin
               if (!cs_rise_s && sclk_rise_s && mode_ok_s) begin
                  if (bit_cnt_r == {CNT_W{1'b0}}) begin
                     overrun_r <= 1'b1;
                  end else begin
                     bit_cnt_r <= bit_cnt_r - lanes_s;
                     if (op_r) shift_r    <= cap_s;
                     else      adv_pend_r <= 1'b1;
                  end
               end else if (!cs_rise_s && sclk_fall_s && adv_pend_r && !op_r) begin
                  shift_r    <= adv_s;
                  adv_pend_r <= 1'b0;
               end
            end
            DONE: begin
               tx_busy <= 1'b0;
               if ((bit_cnt_r == {CNT_W{1'b0}}) && !overrun_r && mode_ok_s) begin
                  if (op_r) begin
                     rx_data  <= shift_r;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: begin
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

   // transmit buffer: tx_load always has priority over echo
   always_ff @(posedge sys_clk or negedge nrst) begin
      if (!nrst) begin
         tx_buffer_r <= {DATA_WIDTH{1'b0}};
      end else if (tx_load) begin
         tx_buffer_r <= tx_data;
`ifdef QSPI_TARGET_AUTO_ECHO_EN
      end else if (rx_valid) begin
         tx_buffer_r <= rx_data;
`endif
      end
   end

endmodule

// File: tb/tb_qspi_target.sv
// Scoreboard bench for qspi_target: a master task drives frames and queues expected events,
// a monitor pops and compares on rx_valid, frame_err and completed master reads.
`timescale 1ns/1ps
module tb_qspi_target;
   import qspi_pkg::*;

   localparam int HALF = 6;

   logic       sys_clk = 1'b0;
   logic       nrst, cs_n, sclk, operation, tx_load;
   logic [1:0] sel_mode;
   logic [7:0] tx_data, rx_data;
   logic       tx_busy, rx_valid, frame_err;
   wire  [3:0] IO;
   logic [3:0] m_oe, m_do;

   for (genvar i = 0; i < 4; i++) begin : g_m
      assign IO[i] = m_oe[i] ? m_do[i] : 1'bz;
   end

   always #5 sys_clk = ~sys_clk;

   qspi_target dut (
      .sys_clk (sys_clk), .nrst (nrst), .sel_mode (sel_mode), .operation (operation),
      .cs_n (cs_n), .sclk (sclk), .IO (IO), .tx_data (tx_data), .tx_load (tx_load),
      .tx_busy (tx_busy), .rx_data (rx_data), .rx_valid (rx_valid), .frame_err (frame_err)
   );

   typedef enum logic [1:0] {EV_RX = 2'd0, EV_ERR = 2'd1, EV_RD = 2'd2} ev_kind_t;
   typedef struct packed { ev_kind_t kind; logic [7:0] data; } ev_t;

   ev_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       rd_done = 1'b0;
   logic [7:0] rd_word = 8'h00;
   logic [7:0] r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
      exp_q.push_back(ev_t'{kind: k, data: d});
   endtask

   task automatic score(input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: unexpected kind %0d data %h", k, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.data != d) begin
            errors++;
            $display("FAIL event: got kind %0d data %h expected kind %0d data %h", k, d, e.kind, e.data);
         end
      end
   endtask

   // monitor: every DUT-presented event is matched against the head of the queue
   always @(negedge sys_clk) begin
      if (rx_valid)  score(EV_RX, rx_data);
      if (frame_err) score(EV_ERR, 8'h00);
      if (rd_done)   score(EV_RD, rd_word);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic post_rd(input logic [7:0] w);
      @(posedge sys_clk);
      rd_word = w;
      rd_done = 1'b1;
      @(posedge sys_clk);
      rd_done = 1'b0;
   endtask

   // master: CPOL=1, drive on falling sclk, sample on rising sclk
   task automatic frame(input logic [1:0] mode, input logic op, input int nbits,
                        input logic [15:0] wdata, input logic [3:0] exp_oe,
                        output logic [7:0] rdata);
      int          lanes;
      logic        oe_bad;
      logic [15:0] acc;
      lanes  = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
      oe_bad = 1'b0;
      acc    = 16'h0000;
      sel_mode  = mode;
      operation = op;
      cs_n      = 1'b0;
      wait_cyc(HALF);
      for (int g = 0; g < nbits / lanes; g++) begin
         int b;
         b    = nbits - 1 - g * lanes;
         sclk = 1'b0;
         if (op) begin
            m_oe = (lanes == 1) ? 4'b0001 : (lanes == 2) ? 4'b0011 : 4'b1111;
            m_do = 4'b0000;
            for (int l = 0; l < lanes; l++) m_do[l] = wdata[b - l];
         end
         wait_cyc(HALF);
         sclk = 1'b1;
         if (dut.io_oe_s !== exp_oe) oe_bad = 1'b1;
         for (int l = 0; l < lanes; l++) acc = {acc[14:0], (lanes == 1) ? IO[1] : IO[l]};
         wait_cyc(HALF);
      end
      cs_n = 1'b1;
      m_oe = 4'b0000;
      wait_cyc(2);
      check("oe_released_after_cs", {28'h0, dut.io_oe_s}, 32'h0);
      wait_cyc(HALF);
      check("oe_during_frame", {31'h0, oe_bad}, 32'h0);
      rdata = acc[7:0];
   endtask

   initial begin
      nrst = 1'b0; cs_n = 1'b1; sclk = 1'b1; sel_mode = 2'b00; operation = 1'b1;
      tx_load = 1'b0; tx_data = 8'h00; m_oe = 4'b0000; m_do = 4'b0000;
      wait_cyc(3);
      check("rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
      check("rst_oe", {28'h0, dut.io_oe_s}, 32'h0);
      nrst = 1'b1;
      wait_cyc(4);

      expect_ev(EV_RX, 8'hA5);
      frame(2'b00, 1'b1, 8, 16'h00A5, 4'b0000, r);
      expect_ev(EV_ERR, 8'h00);
      frame(2'b00, 1'b1, 4, 16'h000A, 4'b0000, r);
      check("rx_hold_after_short", {24'h0, rx_data}, 32'hA5);
      expect_ev(EV_RX, 8'h3C);
      frame(2'b10, 1'b1, 8, 16'h003C, 4'b0000, r);

      tx_data = 8'hC9; tx_load = 1'b1; wait_cyc(1); tx_load = 1'b0;
      expect_ev(EV_RD, 8'hC9);
      frame(2'b01, 1'b0, 8, 16'h0000, 4'b0011, r);
      post_rd(r);

      // reset in the middle of a Quad read
      tx_data = 8'hF0; tx_load = 1'b1; wait_cyc(1); tx_load = 1'b0;
      sel_mode = 2'b10; operation = 1'b0; cs_n = 1'b0;
      wait_cyc(HALF); sclk = 1'b0; wait_cyc(HALF); sclk = 1'b1;
      check("busy_mid_read", {31'h0, tx_busy}, 32'h1);
      check("quad_group0", {28'h0, IO}, 32'hF);
      wait_cyc(2);
      nrst = 1'b0;
      #1;
      check("rst_mid_oe", {28'h0, dut.io_oe_s}, 32'h0);
      check("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
      check("rst_mid_rx_data", {24'h0, rx_data}, 32'h0);
      cs_n = 1'b1; sclk = 1'b1;
      wait_cyc(2); nrst = 1'b1; wait_cyc(HALF);

      expect_ev(EV_RX, 8'h81);
      frame(2'b00, 1'b1, 8, 16'h0081, 4'b0000, r);
      expect_ev(EV_ERR, 8'h00);
      frame(2'b00, 1'b1, 9, 16'h01FF, 4'b0000, r);
      check("rx_hold_after_overrun", {24'h0, rx_data}, 32'h81);
      expect_ev(EV_ERR, 8'h00);
      frame(2'b11, 1'b0, 8, 16'h0000, 4'b0000, r);

      expect_ev(EV_RX, 8'h5A);
      frame(2'b00, 1'b1, 8, 16'h005A, 4'b0000, r);
`ifdef QSPI_TARGET_AUTO_ECHO_EN
      expect_ev(EV_RD, 8'h5A);
`else
      expect_ev(EV_RD, 8'h00);
`endif
      frame(2'b00, 1'b0, 8, 16'h0000, 4'b0010, r);
      post_rd(r);

      wait_cyc(10);
      check("queue_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
